// File: rtl/riscv_hazard_pkg.sv
// Shared types and helpers for the EX-stage forwarding / load-use hazard unit.
package riscv_hazard_pkg;

   localparam int unsigned DEF_REG_ADDR_W = 5;
   // Slot rd is stored at a fixed width; narrower register indices are zero-extended.
   localparam int unsigned SLOT_RD_W      = 8;
   localparam int unsigned FWD_SEL_RF     = 0;

   typedef struct packed {
      logic                 valid;
      logic [SLOT_RD_W-1:0] rd;
      logic                 reg_write;
      logic                 mem_read;
   } fwd_slot_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) w = i + 1;
      end
      return w;
   endfunction

   function automatic logic is_producer(input fwd_slot_t s);
      return s.valid && s.reg_write && (s.rd != '0);
   endfunction

   function automatic logic load_match(input fwd_slot_t s, input logic [SLOT_RD_W-1:0] src);
      return s.valid && s.reg_write && s.mem_read && (s.rd != '0) && (s.rd == src);
   endfunction

endpackage

// File: rtl/fwd_slot_pipe.sv
// Shift register of retiring-writer records: slot 1 takes the EX instruction,
// slot k takes slot k-1, every cycle.
module fwd_slot_pipe
   import riscv_hazard_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  fwd_slot_t             slot_in,
   output fwd_slot_t [DEPTH:1]   slots
);

   fwd_slot_t [DEPTH:1] slot_d;
   fwd_slot_t [DEPTH:1] slot_q;

   always_comb begin
      slot_d    = slot_q;
      slot_d[1] = slot_in;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
         slot_d[k] = slot_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) slot_q <= '0;
      else       slot_q <= slot_d;
   end

   assign slots = slot_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding from tracked writer slots plus load-use stall
// detection for ID, with a saturating stall-cycle counter.
module hazard_forward_unit
   import riscv_hazard_pkg::*;
#(
   parameter  int unsigned NUM_FWD_STAGES = 2,
   parameter  int unsigned LOAD_LAT       = 1,
   parameter  int unsigned REG_ADDR_W     = DEF_REG_ADDR_W,
   parameter  int unsigned CNT_W          = 32,
   localparam int unsigned SEL_W          = clog2(NUM_FWD_STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic                  flush,
   output logic [SEL_W-1:0]      fwd_a,
   output logic [SEL_W-1:0]      fwd_b,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_count
);

   fwd_slot_t                     ex_slot;
   fwd_slot_t [NUM_FWD_STAGES:1]  slots;
   logic [SLOT_RD_W-1:0]          ex_src1, ex_src2, id_src1, id_src2;
   logic                          hazard;
   logic [CNT_W-1:0]              stall_count_d, stall_count_q;

   always_comb begin
      ex_slot = '{valid: ex_valid, rd: SLOT_RD_W'(ex_rd),
                  reg_write: ex_reg_write, mem_read: ex_mem_read};
      ex_src1 = SLOT_RD_W'(ex_rs1);
      ex_src2 = SLOT_RD_W'(ex_rs2);
      id_src1 = SLOT_RD_W'(id_rs1);
      id_src2 = SLOT_RD_W'(id_rs2);
   end

   fwd_slot_pipe #(
      .DEPTH (NUM_FWD_STAGES)
   ) u_slot_pipe (
      .clk     (clk),
      .reset   (reset),
      .slot_in (ex_slot),
      .slots   (slots)
   );

   // Walk from the oldest slot to the newest so the nearest producer overrides.
   always_comb begin
      logic usable;
      fwd_a = SEL_W'(FWD_SEL_RF);
      fwd_b = SEL_W'(FWD_SEL_RF);
      for (int unsigned k = NUM_FWD_STAGES; k >= 1; k--) begin
         usable = is_producer(slots[k]) && !(slots[k].mem_read && (k <= LOAD_LAT));
         if (usable && (slots[k].rd == ex_src1)) fwd_a = SEL_W'(k);
         if (usable && (slots[k].rd == ex_src2)) fwd_b = SEL_W'(k);
      end
      if (reset) begin
         fwd_a = SEL_W'(FWD_SEL_RF);
         fwd_b = SEL_W'(FWD_SEL_RF);
      end
   end

   // A load at position d (EX = 0, slot k = k) blocks the ID reader while d < LOAD_LAT.
   always_comb begin
      hazard = 1'b0;
      if (id_rs1_used && (id_src1 != '0) && load_match(ex_slot, id_src1)) hazard = 1'b1;
      if (id_rs2_used && (id_src2 != '0) && load_match(ex_slot, id_src2)) hazard = 1'b1;
      for (int unsigned d = 1; d < LOAD_LAT; d++) begin
         if (id_rs1_used && (id_src1 != '0) && load_match(slots[d], id_src1)) hazard = 1'b1;
         if (id_rs2_used && (id_src2 != '0) && load_match(slots[d], id_src2)) hazard = 1'b1;
      end
      stall = hazard && id_valid && !flush && !reset;
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) stall_count_q <= '0;
      else       stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: default config (2 slots, LOAD_LAT 1)
// and a deep config (4 slots, LOAD_LAT 3, 3-bit counter for saturation).
module tb_hazard_forward_unit;

   typedef struct packed {
      logic       reset;
      logic       ex_valid;
      logic [4:0] ex_rd;
      logic       ex_reg_write;
      logic       ex_mem_read;
      logic [4:0] ex_rs1;
      logic [4:0] ex_rs2;
      logic       id_valid;
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic       id_rs1_used;
      logic       id_rs2_used;
      logic       flush;
   } stim_t;

   logic       clk = 1'b0;
   stim_t      sa, sb;
   logic [1:0] a_fwd_a, a_fwd_b;
   logic       a_stall;
   logic [31:0] a_cnt;
   logic [2:0] b_fwd_a, b_fwd_b;
   logic       b_stall;
   logic [2:0] b_cnt;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(
      .NUM_FWD_STAGES (2),
      .LOAD_LAT       (1),
      .REG_ADDR_W     (5),
      .CNT_W          (32)
   ) dut_a (
      .clk          (clk),
      .reset        (sa.reset),
      .ex_valid     (sa.ex_valid),
      .ex_rd        (sa.ex_rd),
      .ex_reg_write (sa.ex_reg_write),
      .ex_mem_read  (sa.ex_mem_read),
      .ex_rs1       (sa.ex_rs1),
      .ex_rs2       (sa.ex_rs2),
      .id_valid     (sa.id_valid),
      .id_rs1       (sa.id_rs1),
      .id_rs2       (sa.id_rs2),
      .id_rs1_used  (sa.id_rs1_used),
      .id_rs2_used  (sa.id_rs2_used),
      .flush        (sa.flush),
      .fwd_a        (a_fwd_a),
      .fwd_b        (a_fwd_b),
      .stall        (a_stall),
      .stall_count  (a_cnt)
   );

   hazard_forward_unit #(
      .NUM_FWD_STAGES (4),
      .LOAD_LAT       (3),
      .REG_ADDR_W     (5),
      .CNT_W          (3)
   ) dut_b (
      .clk          (clk),
      .reset        (sb.reset),
      .ex_valid     (sb.ex_valid),
      .ex_rd        (sb.ex_rd),
      .ex_reg_write (sb.ex_reg_write),
      .ex_mem_read  (sb.ex_mem_read),
      .ex_rs1       (sb.ex_rs1),
      .ex_rs2       (sb.ex_rs2),
      .id_valid     (sb.id_valid),
      .id_rs1       (sb.id_rs1),
      .id_rs2       (sb.id_rs2),
      .id_rs1_used  (sb.id_rs1_used),
      .id_rs2_used  (sb.id_rs2_used),
      .flush        (sb.flush),
      .fwd_a        (b_fwd_a),
      .fwd_b        (b_fwd_b),
      .stall        (b_stall),
      .stall_count  (b_cnt)
   );

   function automatic stim_t with_ex(stim_t s, logic v, logic [4:0] rd, logic rw, logic mr,
                                     logic [4:0] rs1, logic [4:0] rs2);
      s.ex_valid = v;  s.ex_rd = rd;  s.ex_reg_write = rw;  s.ex_mem_read = mr;
      s.ex_rs1 = rs1;  s.ex_rs2 = rs2;
      return s;
   endfunction

   function automatic stim_t with_id(stim_t s, logic v, logic [4:0] rs1, logic [4:0] rs2,
                                     logic u1, logic u2, logic fl);
      s.id_valid = v;  s.id_rs1 = rs1;  s.id_rs2 = rs2;
      s.id_rs1_used = u1;  s.id_rs2_used = u2;  s.flush = fl;
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with a live load-use pattern on the inputs: outputs must stay forced low.
      sa = '0;  sa.reset = 1'b1;
      sa = with_ex(sa, 1, 8, 1, 1, 8, 8);
      sa = with_id(sa, 1, 8, 8, 1, 1, 0);
      sb = '0;  sb.reset = 1'b1;
      sb = with_ex(sb, 1, 9, 1, 1, 9, 9);
      sb = with_id(sb, 1, 9, 9, 1, 1, 0);
      tick();
      check("a_rst_stall", a_stall, 0);
      check("a_rst_fwd_a", a_fwd_a, 0);
      check("a_rst_fwd_b", a_fwd_b, 0);
      check("a_rst_cnt",   a_cnt,   0);
      check("b_rst_stall", b_stall, 0);
      check("b_rst_fwd_a", b_fwd_a, 0);
      check("b_rst_cnt",   b_cnt,   0);
      tick();

      // ---------------- config A: 2 slots, LOAD_LAT 1 ----------------
      sa.reset = 1'b0;
      sa = with_ex(sa, 1, 5, 1, 0, 0, 0);           // addi x5
      sa = with_id(sa, 1, 5, 5, 1, 1, 0);
      #1;
      check("a_alu_nostall", a_stall, 0);
      check("a_alu_fwd_a0",  a_fwd_a, 0);
      tick();
      sa = with_ex(sa, 1, 6, 1, 0, 5, 5);           // add x6,x5,x5
      sa = with_id(sa, 1, 5, 0, 1, 0, 0);
      #1;
      check("a_chain_fwd_a1", a_fwd_a, 1);
      check("a_chain_fwd_b1", a_fwd_b, 1);
      check("a_chain_stall",  a_stall, 0);
      tick();
      sa = with_ex(sa, 1, 10, 1, 0, 5, 6);          // sub x10,x5,x6
      sa = with_id(sa, 0, 0, 0, 0, 0, 0);
      #1;
      check("a_chain_fwd_a2", a_fwd_a, 2);
      check("a_chain_fwd_b1b", a_fwd_b, 1);
      tick();
      sa = with_ex(sa, 1, 7, 1, 0, 0, 0);           // addi x7
      tick();
      sa = with_ex(sa, 1, 7, 1, 0, 0, 0);           // addi x7 again
      tick();
      sa = with_ex(sa, 1, 7, 0, 0, 7, 0);           // reads x7, rd=7 but no write
      #1;
      check("a_dbl_nearest", a_fwd_a, 1);
      tick();
      sa = with_ex(sa, 1, 0, 1, 0, 7, 0);           // writes x0, reads x7
      #1;
      check("a_dbl_skip_nowrite", a_fwd_a, 2);
      check("a_x0_fwd_b",         a_fwd_b, 0);
      tick();
      sa = with_ex(sa, 1, 0, 1, 1, 0, 0);           // lw x0, slot1 holds x0 writer
      sa = with_id(sa, 1, 0, 0, 0, 1, 0);
      #1;
      check("a_x0_slot_fwd_b", a_fwd_b, 0);
      check("a_x0_slot_fwd_a", a_fwd_a, 0);
      check("a_x0_nostall",    a_stall, 0);
      tick();
      sa = with_ex(sa, 1, 8, 1, 1, 0, 0);           // lw x8
      sa = with_id(sa, 1, 8, 3, 1, 0, 0);
      #1;
      check("a_lu_stall",   a_stall, 1);
      check("a_lu_cnt0",    a_cnt,   0);
      tick();
      sa = with_ex(sa, 0, 0, 0, 0, 0, 0);           // bubble
      #1;
      check("a_lu_release", a_stall, 0);
      check("a_lu_cnt1",    a_cnt,   1);
      tick();
      sa = with_ex(sa, 1, 13, 1, 0, 8, 8);          // dependent now in EX
      sa = with_id(sa, 0, 0, 0, 0, 0, 0);
      #1;
      check("a_lu_fwd_a2", a_fwd_a, 2);
      check("a_lu_fwd_b2", a_fwd_b, 2);
      check("a_lu_cnt1b",  a_cnt,   1);
      tick();
      sa = with_ex(sa, 1, 8, 1, 1, 0, 0);           // lw x8, reader on rs2
      sa = with_id(sa, 1, 0, 8, 0, 1, 0);
      #1;
      check("a_rs2_stall", a_stall, 1);
      sa = with_id(sa, 1, 0, 8, 0, 0, 0);
      #1;
      check("a_rs2_unused", a_stall, 0);
      sa = with_id(sa, 1, 0, 8, 0, 1, 1);
      #1;
      check("a_flush_wins", a_stall, 0);
      tick();
      sa = with_ex(sa, 0, 0, 0, 0, 8, 0);           // load in slot1 is not forwardable
      sa = with_id(sa, 0, 0, 0, 0, 0, 0);
      #1;
      check("a_load_slot1_nofwd", a_fwd_a, 0);
      check("a_flush_cnt",        a_cnt,   1);
      tick();

      // ---------------- config B: 4 slots, LOAD_LAT 3, 3-bit counter ----------------
      sb.reset = 1'b0;
      sb = with_ex(sb, 1, 9, 1, 1, 0, 0);           // lw x9
      sb = with_id(sb, 1, 9, 0, 1, 0, 0);
      #1;
      check("b_lu_stall_c0", b_stall, 1);
      check("b_lu_cnt0",     b_cnt,   0);
      tick();
      sb = with_ex(sb, 0, 0, 0, 0, 0, 0);
      #1;
      check("b_lu_stall_c1", b_stall, 1);
      check("b_lu_cnt1",     b_cnt,   1);
      tick();
      #1;
      check("b_lu_stall_c2", b_stall, 1);
      check("b_lu_cnt2",     b_cnt,   2);
      tick();
      sb = with_ex(sb, 0, 0, 0, 0, 9, 0);
      #1;
      check("b_lu_release",  b_stall, 0);
      check("b_lu_cnt3",     b_cnt,   3);
      check("b_load_slot3_nofwd", b_fwd_a, 0);
      tick();
      sb = with_ex(sb, 1, 14, 1, 0, 9, 9);
      sb = with_id(sb, 0, 0, 0, 0, 0, 0);
      #1;
      check("b_lu_fwd_a4", b_fwd_a, 4);
      check("b_lu_fwd_b4", b_fwd_b, 4);
      tick();
      sb = with_ex(sb, 1, 9, 1, 1, 0, 0);           // second lw x9
      sb = with_id(sb, 1, 9, 0, 1, 0, 0);
      #1;
      check("b_2nd_stall_c0", b_stall, 1);
      tick();
      sb = with_ex(sb, 0, 0, 0, 0, 0, 0);
      #1;
      check("b_2nd_stall_c1", b_stall, 1);
      check("b_2nd_cnt4",     b_cnt,   4);
      tick();
      sb.flush = 1'b1;
      #1;
      check("b_flush_c2",     b_stall, 0);
      check("b_cnt5",         b_cnt,   5);
      sb.flush = 1'b0;
      #1;
      check("b_noflush_c2",   b_stall, 1);
      sb.reset = 1'b1;
      #1;
      check("b_rst_mid_stall", b_stall, 0);
      tick();
      sb.reset = 1'b0;
      sb = with_ex(sb, 0, 0, 0, 0, 9, 9);
      #1;
      check("b_post_rst_stall", b_stall, 0);
      check("b_post_rst_cnt",   b_cnt,   0);
      check("b_post_rst_fwd_a", b_fwd_a, 0);
      check("b_post_rst_fwd_b", b_fwd_b, 0);
      tick();

      // Hold a load-use hazard in EX every cycle: counter climbs to 7 and sticks.
      sb = with_ex(sb, 1, 9, 1, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check("b_sat_stall", b_stall, 1);
         check("b_sat_cnt",   b_cnt, (i < 7) ? 32'(i) : 32'd7);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
